// File: rtl/missile_launcher_pkg.sv
// missile_pkg: shared constants, the per-slot state struct and the
// heading-to-velocity helper for the missile launcher.
package missile_pkg;
   localparam int FRAC      = 6;   // fraction bits of x_fx / y_fx
   localparam int VEL_W     = 10;  // signed per-frame velocity width
   localparam int VEL_SHIFT = 11;  // (heading * SPEED) >>> VEL_SHIFT
   localparam int POS_W     = 16;  // fixed-point position width (up to 1024 px)
   localparam int LIFE_W    = 8;   // lifetime counter width (LIFE < 256)

   typedef struct packed {
      logic                    active;
      logic [POS_W-1:0]        x_fx;
      logic [POS_W-1:0]        y_fx;
      logic signed [VEL_W-1:0] vx;
      logic signed [VEL_W-1:0] vy;
      logic [LIFE_W-1:0]       life;
   } missile_t;

   // Per-frame velocity from one signed heading component (+-131071 ~ +-1.0).
   function automatic logic signed [VEL_W-1:0] heading_vel(input logic signed [17:0] h,
                                                           input int speed);
      logic signed [21:0] p;
      p = 22'(h) * 22'(speed);
      return VEL_W'(p >>> VEL_SHIFT);
   endfunction
endpackage

// File: rtl/missile_launcher_if.sv
// missile_launcher_if: per-slot missile bus between the launcher and the
// draw/collision stages, plus the spawn sound strobe.
interface missile_launcher_if #(
   parameter int N  = 4,
   parameter int XW = 10,
   parameter int YW = 9
);
   logic [N-1:0]          missile_hit;
   logic [N-1:0]          missile_active;
   logic [N-1:0][XW-1:0]  missile_x;
   logic [N-1:0][YW-1:0]  missile_y;
   logic                  fire_sound;

   modport master (input  missile_hit,
                   output missile_active, missile_x, missile_y, fire_sound);
   modport slave  (output missile_hit,
                   input  missile_active, missile_x, missile_y, fire_sound);
endinterface

// File: rtl/missile_launcher_slot.sv
// missile_slot: one missile -- load, move, wrap or off-screen retire, hit
// and kill. MISSILE_WRAP_EN selects wrapping at the screen edges; without it
// a missile leaving the screen retires in the same frame it moves out.
module missile_slot
   import missile_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int XW     = 10,
   parameter int YW     = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          kill_i,
   input  logic          hit_i,
   input  logic          load_i,
   input  logic          move_i,
   input  missile_t      load_val_i,
   output logic          active_o,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o
);
`ifdef MISSILE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   localparam int SW = POS_W + 2;
   localparam logic signed [SW-1:0] XB = SW'(WIDTH << FRAC);
   localparam logic signed [SW-1:0] YB = SW'(HEIGHT << FRAC);

   missile_t             q, d;
   logic signed [SW-1:0] sx, sy, wx, wy;
   logic                 off_x, off_y;

   // Candidate move: add velocity, fold the sum back into [0, bound).
   always_comb begin
      sx    = $signed({2'b00, q.x_fx}) + SW'(q.vx);
      sy    = $signed({2'b00, q.y_fx}) + SW'(q.vy);
      wx    = sx;
      wy    = sy;
      off_x = 1'b0;
      off_y = 1'b0;
      if (sx < 0) begin
         wx = sx + XB; off_x = 1'b1;
      end else if (sx >= XB) begin
         wx = sx - XB; off_x = 1'b1;
      end
      if (sy < 0) begin
         wy = sy + YB; off_y = 1'b1;
      end else if (sy >= YB) begin
         wy = sy - YB; off_y = 1'b1;
      end
   end

   // Next state: kill beats hit beats load beats move. A load only targets a
   // free slot, so a freshly loaded missile never moves in its spawn frame.
   always_comb begin
      d = q;
      if (kill_i) begin
         d.active = 1'b0;
      end else if (hit_i && q.active) begin
         d.active = 1'b0;
      end else if (load_i) begin
         d = load_val_i;
      end else if (move_i && q.active) begin
         d.x_fx = POS_W'(wx);
         d.y_fx = POS_W'(wy);
         d.life = q.life - LIFE_W'(1);
         if (q.life == LIFE_W'(1) || (!WRAP && (off_x || off_y)))
            d.active = 1'b0;
      end
   end

   // Slot state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else     q <= d;
   end

   assign active_o = q.active;
   assign x_o      = q.x_fx[FRAC +: XW];
   assign y_o      = q.y_fx[FRAC +: YW];
endmodule

// File: rtl/missile_launcher.sv
// missile_launcher: fire edge detect, single pending request, spawn cooldown
// and lowest-free-slot spawn into N missile_slot instances. All motion happens
// in the frame_pulse cycle. Optional MISSILE_WRAP_EN (see missile_slot).
module missile_launcher
   import missile_pkg::*;
#(
   parameter int WIDTH    = 640,
   parameter int HEIGHT   = 480,
   parameter int N        = 4,
   parameter int SPEED    = 4,
   parameter int LIFE     = 40,
   parameter int COOLDOWN = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       game_over,
   input  logic                       fire,
   input  logic                       frame_pulse,
   input  logic [$clog2(WIDTH)-1:0]   ship_x,
   input  logic [$clog2(HEIGHT)-1:0]  ship_y,
   input  logic signed [17:0]         sin_val,
   input  logic signed [17:0]         cos_val,
   missile_launcher_if.master         mb
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   logic          fire_q, pending_q, pending_d, sound_q;
   logic [CW-1:0] cd_q, cd_d;
   logic [N-1:0]  act;
   logic [IW-1:0] free_idx;
   logic          free_any, fire_rise, spawn;
   missile_t      load_val;

   // Lowest-index free slot, from the pre-edge active vector.
   always_comb begin
      free_idx = '0;
      free_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!act[i]) begin
            free_idx = IW'(i);
            free_any = 1'b1;
         end
      end
   end

   assign fire_rise = fire & ~fire_q;
   assign spawn     = frame_pulse & pending_q & (cd_q == '0) & ~game_over & free_any;

   // Spawn payload: ship centre, heading-scaled velocity (y grows downward).
   always_comb begin
      load_val        = '0;
      load_val.active = 1'b1;
      load_val.x_fx   = POS_W'({ship_x, {FRAC{1'b0}}});
      load_val.y_fx   = POS_W'({ship_y, {FRAC{1'b0}}});
      load_val.vx     = heading_vel(sin_val, SPEED);
      load_val.vy     = -heading_vel(cos_val, SPEED);
      load_val.life   = LIFE_W'(LIFE);
   end

   // Pending request and cooldown; game_over wipes both.
   always_comb begin
      pending_d = pending_q;
      cd_d      = cd_q;
      if (game_over) begin
         pending_d = 1'b0;
         cd_d      = '0;
      end else if (spawn) begin
         pending_d = 1'b0;
         cd_d      = CW'(COOLDOWN);
      end else begin
         if (fire_rise) pending_d = 1'b1;
         if (frame_pulse && cd_q != '0) cd_d = cd_q - CW'(1);
      end
   end

   // Control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fire_q    <= 1'b0;
         pending_q <= 1'b0;
         cd_q      <= '0;
         sound_q   <= 1'b0;
      end else begin
         fire_q    <= fire;
         pending_q <= pending_d;
         cd_q      <= cd_d;
         sound_q   <= spawn;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_slot
      missile_slot #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_slot (
         .clk        (clk),
         .rst        (reset),
         .kill_i     (game_over),
         .hit_i      (mb.missile_hit[g]),
         .load_i     (spawn && (free_idx == IW'(g))),
         .move_i     (frame_pulse),
         .load_val_i (load_val),
         .active_o   (act[g]),
         .x_o        (mb.missile_x[g]),
         .y_o        (mb.missile_y[g])
      );
   end

   assign mb.missile_active = act;
   assign mb.fire_sound     = sound_q;
endmodule

// File: tb/tb_missile_launcher.sv
// tb_missile_launcher: directed stimulus, a frame-level behavioural model
// compared every cycle, and literal expectations for the key scenarios.
module tb_missile_launcher;
   localparam int WIDTH = 640, HEIGHT = 480, N = 4, SPEED = 4, LIFE = 40, COOLDOWN = 8;
   localparam int XB = WIDTH * 64, YB = HEIGHT * 64;
`ifdef MISSILE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1, game_over = 1'b0, fire = 1'b0, frame_pulse = 1'b0;
   logic [9:0] ship_x = '0;
   logic [8:0] ship_y = '0;
   logic signed [17:0] sin_val = '0, cos_val = '0;
   int n_cmp = 0, n_bad = 0;

   missile_launcher_if #(.N(N), .XW(10), .YW(9)) mb ();

   missile_launcher #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .N(N), .SPEED(SPEED),
                      .LIFE(LIFE), .COOLDOWN(COOLDOWN)) dut (
      .clk(clk), .reset(reset), .game_over(game_over), .fire(fire),
      .frame_pulse(frame_pulse), .ship_x(ship_x), .ship_y(ship_y),
      .sin_val(sin_val), .cos_val(cos_val), .mb(mb));

   always #5 clk = ~clk;

   // ---------------- behavioural model (frame-level rules) ----------------
   bit m_act[N];
   int m_x[N], m_y[N], m_vx[N], m_vy[N], m_life[N];
   bit m_pend, m_snd, m_fprev;
   int m_cd;

   always @(posedge clk or posedge reset) begin
      int fs, nx, ny;
      bit sp;
      if (reset) begin
         for (int i = 0; i < N; i++) m_act[i] = 0;
         m_pend = 0; m_snd = 0; m_fprev = 0; m_cd = 0;
      end else begin
         fs = -1;
         for (int i = N - 1; i >= 0; i--) if (!m_act[i]) fs = i;
         sp = frame_pulse && m_pend && m_cd == 0 && !game_over && fs >= 0;
         for (int i = 0; i < N; i++) begin
            if (!m_act[i]) continue;
            if (game_over || mb.missile_hit[i]) m_act[i] = 0;
            else if (frame_pulse) begin
               nx = m_x[i] + m_vx[i];
               ny = m_y[i] + m_vy[i];
               m_life[i] = m_life[i] - 1;
               if (m_life[i] == 0) m_act[i] = 0;
               if (WRAP) begin
                  nx = ((nx % XB) + XB) % XB;
                  ny = ((ny % YB) + YB) % YB;
               end else if (nx < 0 || nx >= XB || ny < 0 || ny >= YB) m_act[i] = 0;
               m_x[i] = nx;
               m_y[i] = ny;
            end
         end
         if (sp) begin
            m_act[fs]  = 1;
            m_x[fs]    = ship_x * 64;
            m_y[fs]    = ship_y * 64;
            m_vx[fs]   = (int'(sin_val) * SPEED) >>> 11;
            m_vy[fs]   = -((int'(cos_val) * SPEED) >>> 11);
            m_life[fs] = LIFE;
         end
         if (game_over) begin
            m_pend = 0; m_cd = 0;
         end else if (sp) begin
            m_pend = 0; m_cd = COOLDOWN;
         end else begin
            if (fire && !m_fprev) m_pend = 1;
            if (frame_pulse && m_cd > 0) m_cd = m_cd - 1;
         end
         m_snd   = sp;
         m_fprev = fire;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [N-1:0] ea;
      for (int i = 0; i < N; i++) ea[i] = m_act[i];
      n_cmp++;
      if (mb.missile_active !== ea || mb.fire_sound !== m_snd) begin
         n_bad++;
         $display("FAIL model_state t=%0t: active=%b sound=%b, required active=%b sound=%b",
                  $time, mb.missile_active, mb.fire_sound, ea, m_snd);
      end
      for (int i = 0; i < N; i++) begin
         if (m_act[i]) begin
            n_cmp++;
            if (int'(mb.missile_x[i]) !== m_x[i] / 64 || int'(mb.missile_y[i]) !== m_y[i] / 64) begin
               n_bad++;
               $display("FAIL model_pos slot%0d t=%0t: (%0d,%0d), required (%0d,%0d)",
                        i, $time, mb.missile_x[i], mb.missile_y[i], m_x[i] / 64, m_y[i] / 64);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic frame();
      frame_pulse = 1'b1; step(); frame_pulse = 1'b0;
   endtask

   task automatic frames(input int n);
      repeat (n) begin frame(); step(); end
   endtask

   task automatic press();
      fire = 1'b1; step(); fire = 1'b0; step();
   endtask

   task automatic kill();
      game_over = 1'b1; step(); game_over = 1'b0; step();
   endtask

   initial begin
      mb.missile_hit = '0;
      repeat (3) step();
      chk("reset_active", mb.missile_active, 0);
      chk("reset_sound", mb.fire_sound, 0);
      chk("reset_x0", mb.missile_x[0], 0);
      chk("reset_y0", mb.missile_y[0], 0);
      reset = 1'b0; step();

      // Spawn straight up from screen centre, then one move.
      ship_x = 320; ship_y = 240; sin_val = 0; cos_val = 131071;
      press(); frame();
      chk("spawn_active", mb.missile_active, 1);
      chk("spawn_sound", mb.fire_sound, 1);
      chk("spawn_x", mb.missile_x[0], 320);
      chk("spawn_y", mb.missile_y[0], 240);
      step();
      chk("sound_one_cycle", mb.fire_sound, 0);
      frame();
      chk("move_x", mb.missile_x[0], 320);
      chk("move_y", mb.missile_y[0], 236);
      chk("model_move_yfx", m_y[0], 15105);
      game_over = 1'b1; step(); game_over = 1'b0;
      chk("gameover_clear", mb.missile_active, 0);
      step();

      // Top edge: wrap to the bottom, or retire.
      ship_x = 100; ship_y = 2;
      press(); frame(); step(); frame();
`ifdef MISSILE_WRAP_EN
      chk("wrap_active", mb.missile_active, 1);
      chk("wrap_y", mb.missile_y[0], 478);
      chk("model_wrap_yfx", m_y[0], 30593);
`else
      chk("offscreen_retire", mb.missile_active, 0);
`endif
      kill();

      // Lifetime: alive through 39 moves, gone after the 40th.
      ship_x = 320; ship_y = 240; sin_val = 131071; cos_val = 0;
      press(); frame(); step();
      frames(38); frame();
      chk("life_39_moves", mb.missile_active, 1);
      step(); frame();
      chk("life_40_moves", mb.missile_active, 0);
      step();

      // Back-to-back fire: second waits out the cooldown, extra edge absorbed.
      sin_val = 0; cos_val = 131071;
      press(); frame(); step();
      press(); frame(); step();
      chk("second_held", mb.missile_active, 1);
      frame(); step();
      press();
      frames(6);
      chk("cooldown_hold", mb.missile_active, 1);
      frame();
      chk("cooldown_spawn", mb.missile_active, 3);
      chk("cooldown_sound", mb.fire_sound, 1);
      step();
      frames(10);
      chk("no_third", mb.missile_active, 3);
      kill();

      // Fill all slots, then hit slot 2 together with a spawnable request.
      for (int k = 0; k < 4; k++) begin
         press(); frame(); step(); frames(8);
      end
      chk("four_active", mb.missile_active, 15);
      press();
      mb.missile_hit = 4'b0100; frame(); mb.missile_hit = '0;
      chk("hit_clears", mb.missile_active, 4'b1011);
      chk("hit_no_spawn", mb.fire_sound, 0);
      step(); frame();
      chk("reuse_slot2", mb.missile_active, 15);
      chk("reuse_sound", mb.fire_sound, 1);
      chk("reuse_y2", mb.missile_y[2], 240);
      step();

      // Hit outside a frame, then game_over with three alive and a request held.
      mb.missile_hit = 4'b1000; step(); mb.missile_hit = '0;
      chk("hit_nonframe", mb.missile_active, 4'b0111);
      press();
      game_over = 1'b1; step(); game_over = 1'b0;
      chk("gameover_all", mb.missile_active, 0);
      step();
      frames(12);
      chk("no_spawn_after_go", mb.missile_active, 0);
      press(); frame();
      chk("spawn_after_new_edge", mb.missile_active, 1);
      step();

      // Asynchronous reset between edges.
      @(posedge clk); #2 reset = 1'b1; frame_pulse = 1'b1;
      #1;
      chk("async_reset_active", mb.missile_active, 0);
      chk("async_reset_x0", mb.missile_x[0], 0);
      chk("async_reset_y0", mb.missile_y[0], 0);
      chk("async_reset_sound", mb.fire_sound, 0);
      step(); frame_pulse = 1'b0; reset = 1'b0; step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/missile_launcher.md
# missile_launcher

Spawns, moves, ages and retires the player's missiles. Sits directly downstream of the ship unit: consumes its centre position (`ship_x`, `ship_y`) and heading (`sin_val`, `cos_val`), and feeds per-missile positions to the missile draw/collision stages. All state changes are confined to the one-cycle `frame_pulse` (vertical blank), so positions are stable for the whole visible frame.

## Interface
- `WIDTH`, 640, screen width in pixels
- `HEIGHT`, 480, screen height in pixels
- `N`, 4, missile slots
- `SPEED`, 4, velocity multiplier (1..7)
- `LIFE`, 40, lifetime in frames
- `COOLDOWN`, 8, minimum frames between spawns
---
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `game_over`  in  1  kills all missiles and blocks spawning
- `fire`  in  1  fire button, already synchronous to `clk`
- `frame_pulse`  in  1  one cycle per frame, in vertical blank
- `ship_x`  in  clog2(WIDTH)  ship centre x
- `ship_y`  in  clog2(HEIGHT)  ship centre y
- `sin_val`, `cos_val`  in  18 signed  heading; ±131071 ≈ ±1.0
- `missile_hit`  in  N  per-slot hit from collision logic
- `missile_active`  out  N  slot alive
- `missile_x`  out  N×clog2(WIDTH)  integer x per slot
- `missile_y`  out  N×clog2(HEIGHT)  integer y per slot
- `fire_sound`  out  1  one-cycle spawn strobe

## Operation
- Position format: unsigned fixed point with `FRAC`=6 fraction bits. Outputs are `x_fx >> 6`.
- Fire request
  - A rising edge of `fire` sets `pending`.
  - At most one request is held; further edges while `pending` is set are absorbed.
- Spawn
  - Happens only in a `frame_pulse` cycle, and only when `pending` is set, `cooldown`==0, `game_over`==0 and a free slot exists.
  - Uses the lowest-index free slot.
  - Loads `x_fx=ship_x<<6`, `y_fx=ship_y<<6`, `vx=(sin_val*SPEED)>>>11`, `vy=-((cos_val*SPEED)>>>11)` (arithmetic shift, 10-bit signed result), and `life=LIFE`.
  - Clears `pending`, reloads `cooldown=COOLDOWN`, and pulses `fire_sound`.
- Pending request with no free slot: stays pending and is retried every frame.
- Pending request while `cooldown`≠0: stays pending.
- Cooldown: in every `frame_pulse` cycle, if `cooldown`≠0 it decrements by 1.
- Move, for each active slot in a `frame_pulse` cycle:
  - `x_fx += vx` and `y_fx += vy`.
  - `life` decrements; when the old `life`==1 the slot goes inactive.
  - A slot spawned in this same cycle does not move.
- Wrap: if the sum is <0, add `WIDTH<<6` (or `HEIGHT<<6`); if it is ≥ that bound, subtract it.
- Hit: `missile_hit[i]` while slot `i` is active clears it on the next edge, in any cycle.
  - Hit has priority over move.
  - A slot freed by a hit is not reusable by a spawn in the same cycle; the spawn sees the pre-edge active vector.
- `game_over`: synchronously clears all slots, `pending`, and `cooldown`, and suppresses `fire_sound`.

## Timing
- Reset (async, active-high): all `missile_active`, `missile_x`, `missile_y`, `fire_sound`, `pending`, `cooldown`, and the `fire` edge register are 0.
- `fire` rising at cycle t → `pending`=1 at t+1.
- Spawn in `frame_pulse` cycle f → `missile_active[i]`, position outputs and `fire_sound` are valid at f+1. `fire_sound` lasts exactly 1 cycle.
- Move/retire in `frame_pulse` cycle f → outputs updated at f+1.
- `missile_hit` at cycle h → `missile_active[i]`=0 at h+1.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `MISSILE_WRAP_EN` defined: the wrap rules above apply.
- `MISSILE_WRAP_EN` undefined: a slot whose updated position falls outside [0, bound) goes inactive instead of wrapping, in the same cycle as the move.

## Structure
- Package `missile_pkg`:
  - `FRAC`
  - `missile_t` struct (`active`, `x_fx`, `y_fx`, signed `vx`/`vy`, `life`)
  - velocity width constant
  - shift constant 11
- Sub-module `missile_slot`, instantiated N times. It holds one `missile_t` and handles load, move, wrap/retire, hit and kill.
- The top level owns edge detect, `pending`, `cooldown` and the free-slot priority encoder.

## Test plan
- Ship (320,240), sin=0, cos=131071, fire, then 1 frame_pulse → slot 0 active at (320,240), `fire_sound` 1 cycle; next frame_pulse → y_fx=15105, `missile_y`=236, `missile_x`=320.
- Ship (100,2), same heading, wrap on → after one move y_fx=30593, `missile_y`=478. With wrap off → slot 0 inactive.
- Spawn one missile with LIFE=40 → active through 39 moves, inactive after the 40th frame_pulse.
- Fire edges in 2 consecutive frames → first spawns; second stays pending and spawns 8 frames later into slot 1; an extra edge meanwhile creates no third missile.
- All 4 slots active, `missile_hit[2]` and a spawnable request in the same `frame_pulse` cycle → slot 2 cleared, no spawn; spawn into slot 2 on the next frame_pulse.
- `game_over` pulse with 3 active and `pending` set → all inactive next cycle; no spawn on following frames until a new fire edge after `game_over` drops. Assert `reset` mid-frame → all outputs 0 immediately.
